// File: rtl/l2_input_arbiter.sv
// l2_input_arbiter: front-end transaction scheduler for the L2 core.
// Picks one eligible input channel per IDLE cycle (zero-latency ready) and
// holds its one-hot grant until the L2 FSM signals txn_done.
// Optional CPU starvation guard: define L2_ARB_STARVE_GUARD_EN.
module l2_input_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l2_rsp_in_valid,
  input  logic       l2_fwd_in_valid,
  input  logic       l2_fence_valid,
  input  logic       l2_flush_valid,
  input  logic       l2_cpu_req_valid,
  input  logic       fwd_stall,
  input  logic       set_conflict,
  input  logic       evict_stall,
  input  logic       ongoing_atomic,
  input  logic       mshr_empty,
  input  logic       mshr_full,
  input  logic       txn_done,
  output logic       l2_rsp_in_ready,
  output logic       l2_fwd_in_ready,
  output logic       l2_fence_ready,
  output logic       l2_flush_ready,
  output logic       l2_cpu_req_ready,
  output logic [4:0] grant,
  output logic       busy,
  output logic [7:0] starve_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [4:0] grant_q, grant_d;
  logic [4:0] elig;
  logic [4:0] win;
  logic [7:0] starve_q;
  logic       cpu_first;

  // Per-channel eligibility; bit order matches grant (4 rsp .. 0 cpu).
  assign elig[4] = l2_rsp_in_valid;
  assign elig[3] = l2_fwd_in_valid && !fwd_stall;
  assign elig[2] = l2_fence_valid && mshr_empty;
  assign elig[1] = l2_flush_valid && mshr_empty && !ongoing_atomic;
  assign elig[0] = l2_cpu_req_valid && !set_conflict && !evict_stall && !mshr_full;

  // Once the starvation count saturates the CPU jumps ahead of everything but rsp.
  // Without the guard starve_q is constant zero, so this never fires.
  assign cpu_first = (starve_q == LIMIT);

  // Winner selection; only in IDLE and never while reset is held, so no ready
  // can pulse for a transaction that could not be registered.
  always_comb begin
    win = 5'b00000;
    if (!rst && state_q == IDLE) begin
      if (elig[4])                   win = 5'b10000;
      else if (cpu_first && elig[0]) win = 5'b00001;
      else if (elig[3])              win = 5'b01000;
      else if (elig[2])              win = 5'b00100;
      else if (elig[1])              win = 5'b00010;
      else if (elig[0])              win = 5'b00001;
    end
  end

  // Next-state logic: accept a winner in IDLE, release on txn_done in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|win) begin
          grant_d = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (txn_done) begin
          grant_d = 5'b00000;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 5'b00000;
        state_d = IDLE;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 5'b00000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef L2_ARB_STARVE_GUARD_EN
  logic [7:0] starve_d;

  // Count non-CPU acceptances made while the CPU was eligible; any IDLE cycle
  // with the CPU ineligible, or a CPU acceptance, resets the count.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!elig[0] || win[0])
        starve_d = 8'd0;
      else if ((|win) && starve_q != LIMIT)
        starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= 8'd0;
    else     starve_q <= starve_d;
  end
`else
  assign starve_q = 8'd0;
`endif

  assign l2_rsp_in_ready  = win[4];
  assign l2_fwd_in_ready  = win[3];
  assign l2_fence_ready   = win[2];
  assign l2_flush_ready   = win[1];
  assign l2_cpu_req_ready = win[0];
  assign grant            = grant_q;
  assign busy             = (state_q == BUSY);
  assign starve_cnt       = starve_q;

endmodule

// File: tb/tb_l2_input_arbiter.sv
// Directed testbench for l2_input_arbiter (STARVE_LIMIT = 3).
module tb_l2_input_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] vld = 5'b00000;  // {rsp, fwd, fence, flush, cpu}
  logic       fwd_stall = 1'b0, set_conflict = 1'b0, evict_stall = 1'b0;
  logic       ongoing_atomic = 1'b0, mshr_empty = 1'b1, mshr_full = 1'b0;
  logic       txn_done = 1'b0;
  logic [4:0] rdy;
  logic [4:0] grant;
  logic       busy;
  logic [7:0] starve_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_input_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .l2_rsp_in_valid  (vld[4]),
    .l2_fwd_in_valid  (vld[3]),
    .l2_fence_valid   (vld[2]),
    .l2_flush_valid   (vld[1]),
    .l2_cpu_req_valid (vld[0]),
    .fwd_stall        (fwd_stall),
    .set_conflict     (set_conflict),
    .evict_stall      (evict_stall),
    .ongoing_atomic   (ongoing_atomic),
    .mshr_empty       (mshr_empty),
    .mshr_full        (mshr_full),
    .txn_done         (txn_done),
    .l2_rsp_in_ready  (rdy[4]),
    .l2_fwd_in_ready  (rdy[3]),
    .l2_fence_ready   (rdy[2]),
    .l2_flush_ready   (rdy[1]),
    .l2_cpu_req_ready (rdy[0]),
    .grant            (grant),
    .busy             (busy),
    .starve_cnt       (starve_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge in IDLE. Expects channel exp to be
  // accepted this cycle, then finishes it with one txn_done BUSY cycle.
  // keep=1 leaves the accepted valid asserted (back-to-back requests).
  task automatic txn(input string tag, input logic [4:0] exp, input bit keep);
    @(negedge clk);
    chk({tag, "_ready"}, {3'b0, rdy}, {3'b0, exp});
    @(posedge clk); #1;
    if (!keep) vld = vld & ~exp;
    txn_done = 1'b1;
    @(negedge clk);
    chk({tag, "_grant"}, {3'b0, grant}, {3'b0, exp});
    chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
    chk({tag, "_busy_rdy"}, {3'b0, rdy}, 8'd0);
    @(posedge clk); #1;
    txn_done = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    vld = 5'b11111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {3'b0, rdy}, 8'd0);
    chk("rst_grant", {3'b0, grant}, 8'd0);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_starve", starve_cnt, 8'd0);

    // ---- release, accept rsp, then async reset mid-BUSY ----
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_rdy", {3'b0, rdy}, 8'b00010000);
    @(negedge clk);
    chk("rel_grant", {3'b0, grant}, 8'b00010000);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", {3'b0, grant}, 8'd0);
    chk("arst_busy", {7'b0, busy}, 8'd0);
    chk("arst_rdy", {3'b0, rdy}, 8'd0);
    chk("arst_starve", starve_cnt, 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    txn("post_rst_rsp", 5'b10000, 1'b0);
    vld = 5'b00000;
    @(posedge clk); #1;

    // ---- priority order rsp > fwd > cpu ----
    vld = 5'b11001;
    txn("ord_rsp", 5'b10000, 1'b0);
    txn("ord_fwd", 5'b01000, 1'b0);
    txn("ord_cpu", 5'b00001, 1'b0);
    @(negedge clk);
    chk("ord_idle_rdy", {3'b0, rdy}, 8'd0);
    @(posedge clk); #1;

    // ---- fence blocked by non-empty MSHR, cpu goes first ----
    mshr_empty = 1'b0;
    vld = 5'b00101;
    txn("fence_cpu", 5'b00001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fence_blocked_rdy", {3'b0, rdy}, 8'd0);
      chk("fence_blocked_busy", {7'b0, busy}, 8'd0);
      @(posedge clk); #1;
    end
    mshr_empty = 1'b1;
    txn("fence_go", 5'b00100, 1'b0);

    // ---- flush blocked by atomic, ready is combinational ----
    ongoing_atomic = 1'b1;
    vld = 5'b00010;
    @(negedge clk);
    chk("flush_atomic_rdy", {3'b0, rdy}, 8'd0);
    @(posedge clk); #1;
    ongoing_atomic = 1'b0;
    #1;
    chk("flush_comb_rdy", {3'b0, rdy}, 8'b00000010);
    txn("flush_go", 5'b00010, 1'b0);

    // ---- long BUSY with inputs toggling ----
    vld = 5'b01000;
    @(negedge clk);
    chk("hold_acc_rdy", {3'b0, rdy}, 8'b00001000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vld = 5'(i * 7 + 3);
      fwd_stall = i[0];
      mshr_full = i[1];
      @(negedge clk);
      chk("hold_grant", {3'b0, grant}, 8'b00001000);
      chk("hold_busy", {7'b0, busy}, 8'd1);
      chk("hold_rdy", {3'b0, rdy}, 8'd0);
    end
    @(posedge clk); #1;
    vld = 5'b00000;
    fwd_stall = 1'b0;
    mshr_full = 1'b0;
    txn_done = 1'b1;
    @(posedge clk); #1;
    txn_done = 1'b0;
    @(negedge clk);
    chk("hold_release_busy", {7'b0, busy}, 8'd0);
    chk("hold_release_grant", {3'b0, grant}, 8'd0);
    @(posedge clk); #1;

    // ---- starvation: fwd streaming, cpu waiting ----
    vld = 5'b01001;
`ifdef L2_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 3; i++) begin
      txn("starve_fwd", 5'b01000, 1'b1);
      chk("starve_cnt_inc", starve_cnt, 8'(i + 1));
    end
    txn("starve_cpu", 5'b00001, 1'b0);
    chk("starve_cnt_clr", starve_cnt, 8'd0);
`else
    for (int i = 0; i < 5; i++) begin
      txn("nostarve_fwd", 5'b01000, 1'b1);
      chk("nostarve_cnt", starve_cnt, 8'd0);
    end
`endif
    vld = 5'b00000;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_input_arbiter.md
# l2_input_arbiter

Transaction-level scheduler at the front of the L2 core. Each cycle it arbitrates among the five input channels: response-in, forward-in, fence, flush and CPU request. It applies the core's stall conditions (forward stall, set conflict, eviction stall, MSHR occupancy, ongoing atomic) and hands exactly one accepted transaction at a time to the L2 FSM. It holds that transaction's one-hot grant until the FSM reports completion.

## Interface
- `STARVE_LIMIT`, default 8: number of consecutive non-CPU grants tolerated while an eligible CPU request waits (range 1–255).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active high.
- `l2_rsp_in_valid` in 1: response-in request.
- `l2_fwd_in_valid` in 1: forward-in request.
- `l2_fence_valid` in 1: fence request.
- `l2_flush_valid` in 1: flush request.
- `l2_cpu_req_valid` in 1: CPU request.
- `fwd_stall` in 1: forward blocked by the core.
- `set_conflict` in 1: CPU set conflict.
- `evict_stall` in 1: eviction in progress.
- `ongoing_atomic` in 1: atomic sequence open.
- `mshr_empty` in 1: MSHR count is 0.
- `mshr_full` in 1: MSHR count equals N_MSHR.
- `txn_done` in 1: FSM finished the granted transaction.
- `l2_rsp_in_ready`, `l2_fwd_in_ready`, `l2_fence_ready`, `l2_flush_ready`, `l2_cpu_req_ready` out 1 each: accept pulses.
- `grant` out 5: one-hot active transaction; bit 4 rsp, bit 3 fwd, bit 2 fence, bit 1 flush, bit 0 cpu.
- `busy` out 1: a transaction is held.
- `starve_cnt` out 8: current starvation count (0 when the guard is compiled out).

## Operation
- Eligibility:
  - rsp: valid.
  - fwd: valid && !fwd_stall.
  - fence: valid && mshr_empty.
  - flush: valid && mshr_empty && !ongoing_atomic.
  - cpu: valid && !set_conflict && !evict_stall && !mshr_full.
- Base priority: rsp > fwd > fence > flush > cpu.
- FSM states:
  - IDLE: the highest-priority eligible channel wins. Its ready is driven combinationally (ready = valid && win). On that edge the arbiter registers grant, sets busy and enters BUSY. If nothing is eligible it stays in IDLE with all readies at 0.
  - BUSY: all readies held at 0 and grant held stable. txn_done clears grant and busy and returns to IDLE on the same edge.
- txn_done in IDLE is ignored.
- Readies are never asserted without the matching valid. At most one ready is high in any cycle.
- Withdrawing a valid before acceptance is legal; arbitration re-evaluates every IDLE cycle with no retained preference.
- Reset mid-transaction: state goes to IDLE and grant, busy and starve_cnt are cleared. The aborted transaction is not replayed.

## Timing
- Reset values: every ready 0, grant 5'b0, busy 0, starve_cnt 0.
- Acceptance latency: 0 cycles. The ready appears in the first IDLE cycle in which the channel is the winner.
- grant and busy become visible the cycle after acceptance.
- Minimum period per transaction is 2 cycles: the accept cycle, plus one BUSY cycle with txn_done asserted.
- Stall inputs are sampled only in IDLE. A change during BUSY has no effect on the held grant.

## Configuration
- `L2_ARB_STARVE_GUARD_EN` defined:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each non-CPU acceptance made while the CPU channel is eligible.
  - It clears to 0 on CPU acceptance, and on any IDLE cycle in which the CPU is not eligible.
  - When starve_cnt == STARVE_LIMIT, priority becomes rsp > cpu > fwd > fence > flush; rsp is never demoted.
- Undefined: base priority only, and starve_cnt is tied to 0.

## Test plan
- Reset with every valid high and rst asserted mid-BUSY: all outputs go to 0 asynchronously. After release, rsp is accepted in the first cycle and grant = 5'b10000 the next cycle.
- rsp, fwd and cpu valid together and all eligible: rsp accepted. After txn_done, fwd is accepted, then cpu. Grants in order 10000, 01000, 00001, each transaction 2 cycles.
- Fence valid with mshr_empty = 0 for 5 cycles, cpu valid and eligible: cpu accepted first. After mshr_empty rises, the fence is accepted in the next IDLE cycle.
- Flush valid with mshr_empty = 1 and ongoing_atomic = 1: no flush ready. Clear ongoing_atomic: flush ready pulses in the same cycle, since readies are combinational.
- Guard on, STARVE_LIMIT = 3, fwd valid continuously, cpu eligible: after 3 fwd grants starve_cnt = 3 and the 4th grant goes to cpu, after which starve_cnt = 0. With the guard off, cpu is never granted while fwd stays valid.
- txn_done held low for 10 BUSY cycles while other valids toggle: grant stable, no ready asserted, busy = 1 throughout.
